alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 58 +++++
 rtl/alu_arbiter.sv | 177 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU bus for alu_arbiter.
// The arbiter sits on the slave side; requesters, the ALU and the observer sit on the master side.
interface alu_arbiter_if;
  // Requester 0
  logic        r0_valid;
  logic [3:0]  r0_op;
  logic [15:0] r0_a;
  logic [15:0] r0_b;
  logic [4:0]  r0_imm;
  logic        r0_ready;
  logic        r0_resp_valid;
  logic [15:0] r0_resp_data;
  logic        r0_resp_zero;
  logic        r0_resp_sign;
  logic        r0_resp_err;
  // Requester 1
  logic        r1_valid;
  logic [3:0]  r1_op;
  logic [15:0] r1_a;
  logic [15:0] r1_b;
  logic [4:0]  r1_imm;
  logic        r1_ready;
  logic        r1_resp_valid;
  logic [15:0] r1_resp_data;
  logic        r1_resp_zero;
  logic        r1_resp_sign;
  logic        r1_resp_err;
  // Shared ALU
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_imm;
  logic [15:0] alu_out;
  // Status
  logic        busy;
  logic [15:0] op_count;
  logic [7:0]  err_count;

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b, r0_imm,
    output r0_ready, r0_resp_valid, r0_resp_data, r0_resp_zero, r0_resp_sign, r0_resp_err,
    input  r1_valid, r1_op, r1_a, r1_b, r1_imm,
    output r1_ready, r1_resp_valid, r1_resp_data, r1_resp_zero, r1_resp_sign, r1_resp_err,
    output alu_op, alu_a, alu_b, alu_imm,
    input  alu_out,
    output busy, op_count, err_count
  );

  modport master (
    output r0_valid, r0_op, r0_a, r0_b, r0_imm,
    input  r0_ready, r0_resp_valid, r0_resp_data, r0_resp_zero, r0_resp_sign, r0_resp_err,
    output r1_valid, r1_op, r1_a, r1_b, r1_imm,
    input  r1_ready, r1_resp_valid, r1_resp_data, r1_resp_zero, r1_resp_sign, r1_resp_err,
    input  alu_op, alu_a, alu_b, alu_imm,
    output alu_out,
    input  busy, op_count, err_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// Legal ops are issued for exactly one ALU sampling edge and the result is returned three
// cycles after acceptance; illegal ops are answered with an error response the next cycle.
module alu_arbiter (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] OpNop = 4'b1111;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  typedef struct packed {
    logic [15:0] data;
    logic        zero;
    logic        sign;
    logic        err;
  } resp_t;

  state_e      state_q, state_d;
  logic        last_q, last_d;    // requester granted most recently (1 = r1)
  logic        owner_q, owner_d;  // requester whose legal op is in flight
  logic [3:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_imm_q, alu_imm_d;
  logic [15:0] op_count_q, op_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [1:0]  resp_valid_q, resp_valid_d;
  resp_t       resp_q [2];
  resp_t       resp_d [2];

  logic        gnt_r1;
  logic [1:0]  ready;
  logic        accept;
  logic        illegal;
  logic [3:0]  sel_op;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [4:0]  sel_imm;

  // Round-robin grant, ready generation and payload selection.
  always_comb begin
    if (bus.r0_valid && bus.r1_valid) begin
      gnt_r1 = ~last_q;
    end else begin
      gnt_r1 = bus.r1_valid;
    end
    ready    = 2'b00;
    ready[0] = (state_q == StIdle) && bus.r0_valid && !gnt_r1;
    ready[1] = (state_q == StIdle) && bus.r1_valid && gnt_r1;
    accept   = ready[0] || ready[1];
    if (gnt_r1) begin
      sel_op  = bus.r1_op;
      sel_a   = bus.r1_a;
      sel_b   = bus.r1_b;
      sel_imm = bus.r1_imm;
    end else begin
      sel_op  = bus.r0_op;
      sel_a   = bus.r0_a;
      sel_b   = bus.r0_b;
      sel_imm = bus.r0_imm;
    end
    // Opcodes above 8 are undefined; divide and modulo reject a zero divisor.
    illegal = (sel_op > 4'd8) ||
              (((sel_op == 4'd5) || (sel_op == 4'd7)) && (sel_b == 16'd0));
  end

  // FSM next state, ALU drive and counters.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    alu_op_d    = OpNop;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_imm_d   = alu_imm_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_d = gnt_r1;
          if (illegal) begin
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
          end else begin
            state_d    = StIssue;
            owner_d    = gnt_r1;
            alu_op_d   = sel_op;
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            alu_imm_d  = sel_imm;
            op_count_d = op_count_q + 16'd1;
          end
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Response generation: error replies in IDLE, ALU results at the end of CAPTURE.
  always_comb begin
    resp_valid_d = 2'b00;
    resp_d[0]    = resp_q[0];
    resp_d[1]    = resp_q[1];
    if (accept && illegal) begin
      resp_valid_d[gnt_r1] = 1'b1;
      resp_d[gnt_r1]       = '{data: 16'hFFFF, zero: 1'b0, sign: 1'b1, err: 1'b1};
    end else if (state_q == StCapture) begin
      resp_valid_d[owner_q] = 1'b1;
      resp_d[owner_q]       = '{data: bus.alu_out,
                                zero: (bus.alu_out == 16'd0),
                                sign: bus.alu_out[15],
                                err:  1'b0};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      alu_op_q     <= OpNop;
      alu_a_q      <= 16'd0;
      alu_b_q      <= 16'd0;
      alu_imm_q    <= 5'd0;
      op_count_q   <= 16'd0;
      err_count_q  <= 8'd0;
      resp_valid_q <= 2'b00;
      resp_q[0]    <= '0;
      resp_q[1]    <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_imm_q    <= alu_imm_d;
      op_count_q   <= op_count_d;
      err_count_q  <= err_count_d;
      resp_valid_q <= resp_valid_d;
      resp_q[0]    <= resp_d[0];
      resp_q[1]    <= resp_d[1];
    end
  end

  // Output drive.
  always_comb begin
    bus.r0_ready      = ready[0];
    bus.r1_ready      = ready[1];
    bus.r0_resp_valid = resp_valid_q[0];
    bus.r0_resp_data  = resp_q[0].data;
    bus.r0_resp_zero  = resp_q[0].zero;
    bus.r0_resp_sign  = resp_q[0].sign;
    bus.r0_resp_err   = resp_q[0].err;
    bus.r1_resp_valid = resp_valid_q[1];
    bus.r1_resp_data  = resp_q[1].data;
    bus.r1_resp_zero  = resp_q[1].zero;
    bus.r1_resp_sign  = resp_q[1].sign;
    bus.r1_resp_err   = resp_q[1].err;
    bus.alu_op        = alu_op_q;
    bus.alu_a         = alu_a_q;
    bus.alu_b         = alu_b_q;
    bus.alu_imm       = alu_imm_q;
    bus.busy          = (state_q != StIdle);
    bus.op_count      = op_count_q;
    bus.err_count     = err_count_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model on the shared bus.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: registered result, LFSR steps once per op 1000 sampled.
  logic [15:0] lfsr;
  logic [15:0] lfsr_nx;
  assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= 16'hACE1;
      bus.alu_out <= 16'd0;
    end else begin
      case (bus.alu_op)
        4'd0: bus.alu_out <= bus.alu_a + bus.alu_b + {{11{bus.alu_imm[4]}}, bus.alu_imm};
        4'd1: bus.alu_out <= bus.alu_a - bus.alu_b;
        4'd2: bus.alu_out <= bus.alu_a & bus.alu_b;
        4'd3: bus.alu_out <= bus.alu_a | bus.alu_b;
        4'd4: bus.alu_out <= bus.alu_a ^ bus.alu_b;
        4'd5: bus.alu_out <= (bus.alu_b == 16'd0) ? 16'hFFFF : bus.alu_a / bus.alu_b;
        4'd6: bus.alu_out <= bus.alu_a * bus.alu_b;
        4'd7: bus.alu_out <= (bus.alu_b == 16'd0) ? 16'hFFFF : bus.alu_a % bus.alu_b;
        4'd8: begin
          lfsr        <= lfsr_nx;
          bus.alu_out <= lfsr_nx;
        end
        default: ;
      endcase
    end
  end

  task automatic clear_inputs();
    bus.r0_valid = 1'b0; bus.r0_op = 4'd0; bus.r0_a = 16'd0; bus.r0_b = 16'd0;
    bus.r0_imm = 5'd0;
    bus.r1_valid = 1'b0; bus.r1_op = 4'd0; bus.r1_a = 16'd0; bus.r1_b = 16'd0;
    bus.r1_imm = 5'd0;
  endtask

  // Leaves the bench at a negedge with reset low; the next posedge is the first active edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.alu_op !== 4'hF) begin
      n_fail++; $display("FAIL reset_alu_op: got %h want f", bus.alu_op); end
    n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_imm} !== 37'd0) begin
      n_fail++; $display("FAIL reset_alu_operands: got %h want 0", {bus.alu_a, bus.alu_b}); end
    n_tests++; if ({bus.op_count, bus.err_count} !== 24'd0) begin
      n_fail++; $display("FAIL reset_counters: got %h want 0", {bus.op_count, bus.err_count}); end
    n_tests++;
    if ({bus.r0_resp_valid, bus.r0_resp_err, bus.r0_resp_sign, bus.r0_resp_zero, bus.r0_resp_data,
         bus.r1_resp_valid, bus.r1_resp_err, bus.r1_resp_sign, bus.r1_resp_zero, bus.r1_resp_data}
        !== 40'd0) begin
      n_fail++; $display("FAIL reset_resp: got nonzero want 0"); end
    n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", {bus.r0_ready, bus.r1_ready}); end
  endtask

  // 3 + 4 + sext(5'h1F) = 6
  task automatic test_single();
    do_reset();
    bus.r0_valid = 1'b1; bus.r0_op = 4'd0; bus.r0_a = 16'd3; bus.r0_b = 16'd4;
    bus.r0_imm = 5'h1F;
    #1;
    n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready: got %b want 10", {bus.r0_ready, bus.r1_ready}); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++; if (bus.alu_op !== 4'd0 || bus.alu_a !== 16'd3 || bus.alu_b !== 16'd4) begin
      n_fail++; $display("FAIL single_issue: got op %h a %h want op 0 a 3", bus.alu_op, bus.alu_a);
    end
    n_tests++; if (bus.busy !== 1'b1 || bus.op_count !== 16'd1) begin
      n_fail++; $display("FAIL single_busy_cnt: got %b %h want 1 1", bus.busy, bus.op_count); end
    @(negedge clk); #1;
    n_tests++; if (bus.alu_op !== 4'hF || bus.alu_a !== 16'd3 || bus.r0_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_capture: got op %h a %h rv %b want f 3 0",
                         bus.alu_op, bus.alu_a, bus.r0_resp_valid); end
    @(negedge clk); #1;
    n_tests++;
    if (bus.r0_resp_valid !== 1'b1 || bus.r0_resp_data !== 16'h0006 || bus.r0_resp_zero !== 1'b0
        || bus.r0_resp_sign !== 1'b0 || bus.r0_resp_err !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_resp: got v%b d%h z%b s%b e%b b%b want v1 d0006 z0 s0 e0 b0",
                         bus.r0_resp_valid, bus.r0_resp_data, bus.r0_resp_zero,
                         bus.r0_resp_sign, bus.r0_resp_err, bus.busy); end
    @(negedge clk); #1;
    n_tests++; if (bus.r0_resp_valid !== 1'b0 || bus.r0_resp_data !== 16'h0006) begin
      n_fail++; $display("FAIL single_hold: got v%b d%h want v0 d0006",
                         bus.r0_resp_valid, bus.r0_resp_data); end
  endtask

  // Both requesters hold 5 - 5; grants must alternate starting with r0.
  task automatic test_round_robin();
    int grants [4];
    int n_grant;
    int n_r0;
    int n_r1;
    n_grant = 0; n_r0 = 0; n_r1 = 0;
    do_reset();
    bus.r0_valid = 1'b1; bus.r0_op = 4'd1; bus.r0_a = 16'd5; bus.r0_b = 16'd5;
    bus.r1_valid = 1'b1; bus.r1_op = 4'd1; bus.r1_a = 16'd5; bus.r1_b = 16'd5;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++; if (bus.r0_ready && bus.r1_ready) begin
        n_fail++; $display("FAIL rr_exclusive: got both ready want at most one"); end
      if ((bus.r0_ready || bus.r1_ready) && n_grant < 4) begin
        grants[n_grant] = bus.r1_ready ? 1 : 0;
        n_grant++;
      end
      if (bus.r0_resp_valid) n_r0++;
      if (bus.r1_resp_valid) n_r1++;
      if (bus.r0_resp_valid || bus.r1_resp_valid) begin
        n_tests++;
        if ((bus.r0_resp_valid && (bus.r0_resp_data !== 16'd0 || bus.r0_resp_zero !== 1'b1)) ||
            (bus.r1_resp_valid && (bus.r1_resp_data !== 16'd0 || bus.r1_resp_zero !== 1'b1))) begin
          n_fail++; $display("FAIL rr_resp: got d%h/%h z%b/%b want 0000 z1", bus.r0_resp_data,
                             bus.r1_resp_data, bus.r0_resp_zero, bus.r1_resp_zero); end
      end
      @(negedge clk);
    end
    clear_inputs();
    n_tests++; if (n_grant !== 4) begin
      n_fail++; $display("FAIL rr_count: got %0d grants want 4", n_grant); end
    n_tests++;
    if (n_grant == 4 && (grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1))
    begin
      n_fail++; $display("FAIL rr_order: got %0d%0d%0d%0d want 0101",
                         grants[0], grants[1], grants[2], grants[3]); end
    n_tests++; if (n_r0 != 2 || n_r1 != 1) begin
      n_fail++; $display("FAIL rr_resp_count: got r0 %0d r1 %0d want 2 1", n_r0, n_r1); end
  endtask

  // Modulo by zero from r1 is rejected without touching the ALU.
  task automatic test_reject();
    do_reset();
    bus.r1_valid = 1'b1; bus.r1_op = 4'd7; bus.r1_a = 16'd10; bus.r1_b = 16'd0;
    #1;
    n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rej_ready: got %b want 01", {bus.r0_ready, bus.r1_ready}); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if (bus.r1_resp_valid !== 1'b1 || bus.r1_resp_data !== 16'hFFFF || bus.r1_resp_err !== 1'b1
        || bus.r1_resp_sign !== 1'b1 || bus.r1_resp_zero !== 1'b0) begin
      n_fail++; $display("FAIL rej_resp: got v%b d%h e%b s%b z%b want v1 dffff e1 s1 z0",
                         bus.r1_resp_valid, bus.r1_resp_data, bus.r1_resp_err,
                         bus.r1_resp_sign, bus.r1_resp_zero); end
    n_tests++; if (bus.alu_op !== 4'hF || bus.alu_a !== 16'd0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rej_no_issue: got op %h a %h busy %b want f 0 0",
                         bus.alu_op, bus.alu_a, bus.busy); end
    n_tests++; if (bus.err_count !== 8'd1 || bus.op_count !== 16'd0) begin
      n_fail++; $display("FAIL rej_counts: got err %h op %h want 01 0000",
                         bus.err_count, bus.op_count); end
    @(negedge clk); #1;
    n_tests++; if (bus.r1_resp_valid !== 1'b0 || bus.r1_resp_err !== 1'b1) begin
      n_fail++; $display("FAIL rej_pulse: got v%b e%b want v0 e1",
                         bus.r1_resp_valid, bus.r1_resp_err); end
  endtask

  // LFSR from 16'hACE1 (taps B400): first step E270, second 7138.
  task automatic test_rng();
    logic [15:0] want [2];
    logic [15:0] got [2];
    int          op8_cycles;
    want[0] = 16'hE270;
    want[1] = 16'h7138;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      bus.r0_valid = 1'b1; bus.r0_op = 4'd8; bus.r0_a = 16'd0; bus.r0_b = 16'd0;
      #1;
      n_tests++; if (bus.r0_ready !== 1'b1) begin
        n_fail++; $display("FAIL rng_ready%0d: got %b want 1", r, bus.r0_ready); end
      op8_cycles = 0;
      got[r] = 16'hXXXX;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        clear_inputs();
        #1;
        if (bus.alu_op == 4'd8) op8_cycles++;
        if (c == 3) begin
          n_tests++; if (bus.r0_resp_valid !== 1'b1) begin
            n_fail++; $display("FAIL rng_valid%0d: got %b want 1", r, bus.r0_resp_valid); end
          got[r] = bus.r0_resp_data;
        end
      end
      n_tests++; if (op8_cycles != 1) begin
        n_fail++; $display("FAIL rng_op_width%0d: got %0d cycles want 1", r, op8_cycles); end
      n_tests++; if (got[r] !== want[r]) begin
        n_fail++; $display("FAIL rng_data%0d: got %h want %h", r, got[r], want[r]); end
    end
    n_tests++; if (got[0] === got[1]) begin
      n_fail++; $display("FAIL rng_differ: got %h twice want distinct", got[0]); end
    bus.r0_valid = 1'b1; bus.r0_op = 4'hC; bus.r0_a = 16'd1; bus.r0_b = 16'd1;
    #1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if (bus.r0_resp_valid !== 1'b1 || bus.r0_resp_err !== 1'b1 || bus.r0_resp_data !== 16'hFFFF
        || bus.err_count !== 8'd1 || bus.op_count !== 16'd2) begin
      n_fail++; $display("FAIL rng_bad_op: got v%b e%b d%h ec%h oc%h want v1 e1 dffff ec01 oc0002",
                         bus.r0_resp_valid, bus.r0_resp_err, bus.r0_resp_data,
                         bus.err_count, bus.op_count); end
  endtask

  // Back-to-back rejects every cycle; err_count must stop at ff.
  task automatic test_err_sat();
    do_reset();
    bus.r0_valid = 1'b1; bus.r0_op = 4'h9; bus.r0_a = 16'd1; bus.r0_b = 16'd1;
    repeat (260) @(negedge clk);
    #1;
    n_tests++; if (bus.err_count !== 8'hFF || bus.r0_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL err_saturate: got %h v%b want ff v1",
                         bus.err_count, bus.r0_resp_valid); end
    clear_inputs();
  endtask

  // Reset landing in CAPTURE must swallow the response.
  task automatic test_reset_capture();
    do_reset();
    bus.r0_valid = 1'b1; bus.r0_op = 4'd2; bus.r0_a = 16'hF0F0; bus.r0_b = 16'hFF00;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    #1;
    n_tests++; if (bus.busy !== 1'b1 || bus.op_count !== 16'd1) begin
      n_fail++; $display("FAIL rstcap_pre: got busy %b op %h want 1 0001", bus.busy, bus.op_count);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.r0_resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.op_count !== 16'd0
        || bus.err_count !== 8'd0) begin
      n_fail++; $display("FAIL rstcap_drop: got v%b busy %b op %h err %h want 0 0 0000 00",
                         bus.r0_resp_valid, bus.busy, bus.op_count, bus.err_count); end
    repeat (3) begin
      @(negedge clk); #1;
      n_tests++; if (bus.r0_resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rstcap_late: got v%b want 0", bus.r0_resp_valid); end
    end
  endtask

  // The counter is preset to ffff to reach the wrap without 65536 real issues.
  task automatic test_wrap();
    do_reset();
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    #1;
    n_tests++; if (bus.op_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_preset: got %h want ffff", bus.op_count); end
    bus.r0_valid = 1'b1; bus.r0_op = 4'd3; bus.r0_a = 16'h1200; bus.r0_b = 16'h0034;
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++; if (bus.op_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_count: got %h want 0000", bus.op_count); end
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (bus.r0_resp_valid !== 1'b1 || bus.r0_resp_data !== 16'h1234) begin
      n_fail++; $display("FAIL wrap_resp: got v%b d%h want v1 d1234",
                         bus.r0_resp_valid, bus.r0_resp_data); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_reject();
    test_rng();
    test_err_sat();
    test_reset_capture();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
